// File: rtl/torture_vpu_pkg.sv
// Shared definitions for the vector-unit completion trace path.
// Holds the field widths of a completion event and the packed trace record
// handed to the dump sink. The sequence number occupies the MSBs so that a
// raw dump of the record sorts by capture order.
package torture_vpu_pkg;

  localparam int VADDR_W   = 5;
  localparam int LVADDR_W  = 6;
  localparam int SEW_W     = 3;
  localparam int VLEN_W    = 15;
  localparam int SB_W      = 5;
  localparam int SEQ_W     = 32;
  localparam int FLAGS_W   = 3;
  localparam int MAX_PORTS = 4;
  localparam int PORT_W    = $clog2(MAX_PORTS);

  typedef struct packed {
    logic [SEQ_W-1:0]    seq;
    logic [PORT_W-1:0]   port;
    logic                illegal;
    logic [VADDR_W-1:0]  vreg;
    logic [LVADDR_W-1:0] lreg;
    logic [SEW_W-1:0]    sew;
    logic [VLEN_W-1:0]   vlen;
    logic [FLAGS_W-1:0]  flags;   // {reduction_wi, reduction, widening}
    logic [SB_W-1:0]     sb_id;
  } trace_entry_t;

endpackage

// File: rtl/torture_trace_mwfifo.sv
// N-write / 1-read FIFO of trace records.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers and count only)
//   push_cnt    number of records to write this cycle (0..N_W, never > free)
//   wr_data     compacted write records; slot k lands at wr_ptr + k
//   pop         consume the head record (ignored when empty)
//   head        record at the read pointer, zero while empty
//   count       registered number of stored records
//   free        DEPTH - count
module torture_trace_mwfifo
  import torture_vpu_pkg::*;
#(
  parameter int N_W   = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH):0]   push_cnt,
  input  trace_entry_t             wr_data [N_W],
  input  logic                     pop,
  output trace_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  trace_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop_eff;

  assign pop_eff = pop & (count != '0);
  assign free    = CNT_W'(DEPTH) - count;
  // Storage is not reset, so mask the head while empty to keep it defined.
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_W; k++) begin
      if (CNT_W'(k) < push_cnt) begin
        mem[wr_ptr + AW'(k)] <= wr_data[k];
      end
    end
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop_eff);
      count  <= count + push_cnt - CNT_W'(pop_eff);
    end
  end

endmodule

// File: rtl/torture_trace_vpu_buffer.sv
// Capture buffer for vector-unit completion events.
// Filters illegal events on request, accepts eligible events in ascending
// port order up to the free space seen at the start of the cycle, tags each
// with a global sequence number, and drains them through a valid/ready port.
// Ports:
//   cfg_enable, cfg_drop_illegal       capture controls, effective same cycle
//   cmp_*                              per-port completion event fields
//   cmp_stall                          fewer than N_PORTS slots free
//   trc_valid/trc_ready/trc_entry      head-of-queue trace port
//   occupancy                          stored entry count
//   drop_cnt, overflow                 saturating drop count, sticky drop flag
module torture_trace_vpu_buffer
  import torture_vpu_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int DEPTH   = 8,
  parameter int DROP_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_enable,
  input  logic                          cfg_drop_illegal,
  input  logic [N_PORTS-1:0]            cmp_valid,
  input  logic [N_PORTS-1:0]            cmp_illegal,
  input  logic [N_PORTS*VADDR_W-1:0]    cmp_vreg_dst,
  input  logic [N_PORTS*LVADDR_W-1:0]   cmp_lreg_dst,
  input  logic [N_PORTS*SEW_W-1:0]      cmp_sew,
  input  logic [N_PORTS*VLEN_W-1:0]     cmp_vlen,
  input  logic [N_PORTS*FLAGS_W-1:0]    cmp_flags,
  input  logic [N_PORTS*SB_W-1:0]       cmp_sb_id,
  output logic                          cmp_stall,
  output logic                          trc_valid,
  input  logic                          trc_ready,
  output trace_entry_t                  trc_entry,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [SEQ_W-1:0]  seq;
  logic [CNT_W-1:0]  free;
  logic [CNT_W-1:0]  n_acc;
  logic [CNT_W-1:0]  n_drop;
  trace_entry_t      wr_data [N_PORTS];

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [CNT_W-1:0]  b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(b);
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

  // Rank eligible events in port order; the first `free` of them are taken.
  // A rank among eligible events equals the rank among accepted ones because
  // acceptance is a prefix of the eligible list.
  always_comb begin
    logic [CNT_W-1:0] n_elig;
    logic [CNT_W-1:0] rank [N_PORTS];
    logic [N_PORTS-1:0] acc;
    trace_entry_t ent [N_PORTS];
    logic elig;
    n_elig = '0;
    n_acc  = '0;
    acc    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      elig    = cmp_valid[p] & cfg_enable & ~(cfg_drop_illegal & cmp_illegal[p]);
      rank[p] = n_elig;
      acc[p]  = elig && (n_elig < free);
      if (elig)   n_elig = n_elig + 1'b1;
      if (acc[p]) n_acc  = n_acc + 1'b1;
      ent[p].seq     = seq + SEQ_W'(rank[p]);
      ent[p].port    = PORT_W'(p);
      ent[p].illegal = cmp_illegal[p];
      ent[p].vreg    = cmp_vreg_dst[p*VADDR_W +: VADDR_W];
      ent[p].lreg    = cmp_lreg_dst[p*LVADDR_W +: LVADDR_W];
      ent[p].sew     = cmp_sew[p*SEW_W +: SEW_W];
      ent[p].vlen    = cmp_vlen[p*VLEN_W +: VLEN_W];
      ent[p].flags   = cmp_flags[p*FLAGS_W +: FLAGS_W];
      ent[p].sb_id   = cmp_sb_id[p*SB_W +: SB_W];
    end
    n_drop = n_elig - n_acc;
    // Compact accepted events into write slots 0..n_acc-1.
    for (int k = 0; k < N_PORTS; k++) begin
      wr_data[k] = '0;
      for (int p = 0; p < N_PORTS; p++) begin
        if (acc[p] && (rank[p] == CNT_W'(k))) wr_data[k] = ent[p];
      end
    end
  end

  torture_trace_mwfifo #(
    .N_W   (N_PORTS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_cnt (n_acc),
    .wr_data  (wr_data),
    .pop      (trc_ready),
    .head     (trc_entry),
    .count    (occupancy),
    .free     (free)
  );

  assign trc_valid = (occupancy != '0);
  assign cmp_stall = (free < CNT_W'(N_PORTS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      seq      <= seq + SEQ_W'(n_acc);
      drop_cnt <= sat_add(drop_cnt, n_drop);
      if (n_drop != '0) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/torture_trace_vpu_buffer.md
Name: torture_trace_vpu_buffer

Overview:
Multi-port capture buffer for vector-unit completion events in the torture tracing infrastructure. It accepts up to N_PORTS completion events per cycle and tags each accepted event with a global sequence number. Events are queued in a multi-write / single-read FIFO and drained through a valid/ready trace port to the dump sink. It adds backpressure, illegal-event filtering and drop accounting.

Parameters:
N_PORTS, 2, number of completion ports (1..4)
DEPTH, 8, FIFO entries; power of two, >= N_PORTS
VADDR_W, 5, vector destination register index width
LVADDR_W, 6, logical destination register width
SEW_W, 3, SEW CSR field width
VLEN_W, 15, vector length field width
SB_W, 5, scoreboard id width
SEQ_W, 32, sequence number width
DROP_W, 16, drop counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_enable  in  1  capture enable
cfg_drop_illegal  in  1  filter illegal completions
cmp_valid  in  N_PORTS  per-port completion valid
cmp_illegal  in  N_PORTS  per-port illegal flag
cmp_vreg_dst  in  N_PORTS*VADDR_W  destination vreg
cmp_lreg_dst  in  N_PORTS*LVADDR_W  logical destination
cmp_sew  in  N_PORTS*SEW_W  SEW
cmp_vlen  in  N_PORTS*VLEN_W  vector length
cmp_flags  in  N_PORTS*3  {reduction_wi, reduction, widening}
cmp_sb_id  in  N_PORTS*SB_W  scoreboard id
cmp_stall  out  1  backpressure request to completion logic
trc_valid  out  1  head entry valid
trc_ready  in  1  sink accepts head
trc_entry  out  trace_entry_t  {seq, port, illegal, vreg, lreg, sew, vlen, flags, sb_id}
occupancy  out  $clog2(DEPTH)+1  current entry count
drop_cnt  out  DROP_W  saturating dropped-event count
overflow  out  1  sticky: at least one drop since reset

Behaviour:
- Reset (async, rst_n=0): count=0, read/write pointers=0, seq=0, drop_cnt=0, overflow=0. trc_valid=0, cmp_stall=0, trc_entry=0.
- Eligible event on port p: cmp_valid[p] & cfg_enable & ~(cfg_drop_illegal & cmp_illegal[p]).
- Filtered illegal events: not queued, get no seq, not counted as drops.
- free = DEPTH - count, using the registered count. A same-cycle pop does not free a slot for that cycle's pushes.
- Acceptance: eligible events are taken in ascending port order. The first min(free, n_eligible) are accepted; the rest are dropped.
- Each accepted event is written at wr_ptr + k, where k is its rank among accepted events. It gets seq + k and its port index in trc_entry.port.
- Per cycle: seq += n_accepted; wr_ptr += n_accepted; both wrap modulo their width.
- Drops: drop_cnt += n_dropped, saturating at all-ones. overflow is set and stays set until reset.
- cmp_stall = (free < N_PORTS), combinational from registered count. Upstream holding events is its own responsibility; events presented during stall are still accepted or dropped by the rules above.
- Output: trc_valid = (count != 0); trc_entry = mem[rd_ptr], combinational from storage. When trc_entry is not valid it is don't-care, but the bench compares it only when trc_valid=1.
- Pop on trc_valid & trc_ready: rd_ptr += 1.
- count_next = count + n_accepted - pop.
- Latency: an event accepted at edge t is visible on trc_valid/trc_entry after edge t, one cycle after presentation.
- Order: sequence order equals FIFO order equals dequeue order, with no gaps except wrap.
- Full: free=0 means all eligible events are dropped; a pop that cycle still occurs.
- Empty: trc_ready is ignored; no underflow.
- cfg_enable=0: no pushes; the queue continues draining.
- Toggling cfg_enable or cfg_drop_illegal takes effect the same cycle.
- Reset mid-operation: all queued entries are discarded immediately; trc_valid drops asynchronously.

Decomposition:
- Package torture_vpu_pkg holds the width constants and the trace_entry_t packed struct (seq first, MSB-aligned) shared with the dump sink.
- Sub-module torture_trace_mwfifo: generic N-write/1-read FIFO with inputs push_cnt (0..N_PORTS), a compacted write array and pop; outputs head, count and free.
- The top level does eligibility, compaction/ranking, sequence numbering and drop accounting.

Test Plan:
- Single event on port 0 (vreg 3, sew 2, vlen 16) with trc_ready=1 -> trc_valid high the next cycle; entry seq=0, port=0, vreg=3; occupancy returns to 0 the cycle after.
- Both ports valid in one cycle, trc_ready=0 -> occupancy=2; dequeue gives port0 with seq=0, then port1 with seq=1.
- Fill to DEPTH=8 with trc_ready=0, then present 2 events -> both dropped, drop_cnt=2, overflow=1; cmp_stall has been 1 since occupancy reached 7.
- occupancy=7, 2 events presented, trc_ready=1 -> port0 accepted, port1 dropped (registered free=1); occupancy stays 7; drop_cnt+1.
- cfg_drop_illegal=1, port0 illegal and port1 legal -> only port1 queued, with seq=N where N is the prior seq; drop_cnt unchanged. With cfg_drop_illegal=0 both are queued and illegal=1 is recorded.
- Assert rst_n low with 5 entries queued -> trc_valid=0 immediately; after release occupancy=0, and the next event gets seq=0.
